// File: rtl/williams2_pkg.sv
// Shared constants and types for the williams2 NVRAM upload path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package williams2_pkg;

    localparam int         CMOS_DEPTH  = 1024;   // CMOS nibbles
    localparam int         CMOS_BYTES  = 512;    // packed bytes presented to the HPS
    localparam logic [7:0] NVRAM_INDEX = 8'd4;   // ioctl_index of the NVRAM image

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_READY,
        ST_FETCH_LO,
        ST_WAIT_LO,
        ST_FETCH_HI,
        ST_WAIT_HI,
        ST_DONE
    } upload_state_t;

endpackage

// File: rtl/cmos_nvram_upload.sv
// Upload responder: streams the 1K x 4 CMOS RAM to the HPS as 512 packed bytes.
// Latency: 2*RD_LAT+3 clk_sys edges per in-range byte; out-of-range bytes answer on the request edge.
// Backpressure: ioctl_wait stalls the HPS until the CPU is paused and while each byte is fetched.
module cmos_nvram_upload
    import williams2_pkg::*;
#(
    parameter logic [7:0] INDEX   = NVRAM_INDEX,
    parameter int         CMOS_AW = 10,
    parameter int         RD_LAT  = 1
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ioctl_upload,
    input  logic [15:0]        ioctl_index,
    input  logic               ioctl_rd,
    input  logic [24:0]        ioctl_addr,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_wait,
    output logic               pause_req,
    input  logic               pause_ack,
    output logic [CMOS_AW-1:0] cmos_addr,
    output logic               cmos_rd,
    input  logic [3:0]         cmos_data,
    output logic               busy
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    upload_state_t      state, state_nxt;
    logic               sel, sel_q;
    logic               pend_vld, pend_oor;
    logic [8:0]         pend_a9;
    logic [8:0]         cur_a9;
    logic [3:0]         lo_nib, hi_nib;
    logic [1:0]         lat_cnt;
    logic               lat_done;
    logic               rd_oor;
    logic               req_vld, req_oor;
    logic [8:0]         req_a9;
    logic               accept;
    logic [7:0]         din_nxt;
    logic               wait_nxt, preq_nxt, rd_nxt, busy_nxt;
    logic [CMOS_AW-1:0] addr_nxt;

    assign sel      = ioctl_upload && (ioctl_index == {8'h00, INDEX});
    assign rd_oor   = (ioctl_addr >= 25'(CMOS_BYTES));
    // A request latched while paused takes priority over a live strobe.
    assign req_vld  = pend_vld || ioctl_rd;
    assign req_oor  = pend_vld ? pend_oor : rd_oor;
    assign req_a9   = pend_vld ? pend_a9  : ioctl_addr[8:0];
    assign accept   = sel && pause_ack && req_vld &&
                      ((state == ST_PAUSE) || (state == ST_READY));
    assign lat_done = (lat_cnt == LAT_LAST);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            // Starts high so a session already open across reset is not resumed;
            // the HPS must reopen it.
            sel_q <= 1'b1;
        end else begin
            state <= state_nxt;
            sel_q <= sel;
        end
    end

    // Next-state: abort on sel fall, otherwise walk the fetch sequence.
    always_comb begin
        state_nxt = state;
        if ((state != ST_IDLE) && !sel) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (sel && !sel_q) state_nxt = ST_PAUSE;
                ST_PAUSE:    if (pause_ack)
                                 state_nxt = (accept && !req_oor) ? ST_FETCH_LO : ST_READY;
                ST_READY:    if (!pause_ack)              state_nxt = ST_PAUSE;
                             else if (accept && !req_oor) state_nxt = ST_FETCH_LO;
                ST_FETCH_LO: state_nxt = ST_WAIT_LO;
                ST_WAIT_LO:  if (lat_done) state_nxt = ST_FETCH_HI;
                ST_FETCH_HI: state_nxt = ST_WAIT_HI;
                ST_WAIT_HI:  if (lat_done) state_nxt = ST_DONE;
                ST_DONE:     state_nxt = ST_READY;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        din_nxt  = ioctl_din;
        wait_nxt = 1'b0;
        preq_nxt = 1'b0;
        rd_nxt   = 1'b0;
        addr_nxt = cmos_addr;
        case (state_nxt)
            ST_IDLE:  ;
            ST_READY: preq_nxt = 1'b1;
            ST_FETCH_LO: begin
                wait_nxt = 1'b1;
                preq_nxt = 1'b1;
                rd_nxt   = 1'b1;
                addr_nxt = CMOS_AW'({req_a9, 1'b0});
            end
            ST_FETCH_HI: begin
                wait_nxt = 1'b1;
                preq_nxt = 1'b1;
                rd_nxt   = 1'b1;
                addr_nxt = CMOS_AW'({cur_a9, 1'b1});
            end
            default: begin
                wait_nxt = 1'b1;
                preq_nxt = 1'b1;
            end
        endcase
        if ((state == ST_DONE) && (state_nxt == ST_READY)) begin
            din_nxt = {hi_nib, lo_nib};
        end else if (accept && req_oor) begin
            din_nxt = 8'hFF;
        end
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            cmos_addr  <= '0;
            cmos_rd    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ioctl_din  <= din_nxt;
            ioctl_wait <= wait_nxt;
            pause_req  <= preq_nxt;
            cmos_addr  <= addr_nxt;
            cmos_rd    <= rd_nxt;
            busy       <= busy_nxt;
        end
    end

    // Pending-request latch, byte address, read-latency counter and nibble capture.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld <= 1'b0;
            pend_oor <= 1'b0;
            pend_a9  <= '0;
            cur_a9   <= '0;
            lat_cnt  <= '0;
            lo_nib   <= '0;
            hi_nib   <= '0;
        end else begin
            if (!sel || accept) begin
                pend_vld <= 1'b0;
            end else if (ioctl_rd && !pend_vld &&
                         ((state == ST_PAUSE) || ((state == ST_READY) && !pause_ack))) begin
                pend_vld <= 1'b1;
                pend_oor <= rd_oor;
                pend_a9  <= ioctl_addr[8:0];
            end
            if (state_nxt == ST_FETCH_LO) begin
                cur_a9 <= req_a9;
            end
            if (((state == ST_WAIT_LO) || (state == ST_WAIT_HI)) && !lat_done) begin
                lat_cnt <= lat_cnt + 2'd1;
            end else begin
                lat_cnt <= '0;
            end
            if ((state == ST_WAIT_LO) && lat_done) lo_nib <= cmos_data;
            if ((state == ST_WAIT_HI) && lat_done) hi_nib <= cmos_data;
        end
    end

endmodule

// File: tb/tb_cmos_nvram_upload.sv
// Directed bench for cmos_nvram_upload with RD_LAT=1 and RD_LAT=3 instances.
// Latency: checks exact 2*RD_LAT+3 edge byte latency.
// Backpressure: exercises ioctl_wait during pause, fetch and abort.
module tb_cmos_nvram_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [15:0] ioctl_index;

    logic        ioctl_upload, ioctl_rd, pause_ack;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait, pause_req, cmos_rd, busy;
    logic [9:0]  cmos_addr;
    logic [3:0]  cmos_data;

    logic        ioctl_upload3, ioctl_rd3, pause_ack3;
    logic [24:0] ioctl_addr3;
    logic [7:0]  ioctl_din3;
    logic        ioctl_wait3, pause_req3, cmos_rd3, busy3;
    logic [9:0]  cmos_addr3;
    logic [3:0]  cmos_data3;

    int          checks = 0;
    int          errors = 0;
    int          rd_pulses = 0;
    int          rd_pulses3 = 0;

    logic [3:0]  mem [1024];
    logic [3:0]  q1, s0, s1, s2;

    always #5 clk_sys = ~clk_sys;

    cmos_nvram_upload #(.INDEX(8'd4), .CMOS_AW(10), .RD_LAT(1)) u_dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
        .pause_ack(pause_ack), .cmos_addr(cmos_addr), .cmos_rd(cmos_rd),
        .cmos_data(cmos_data), .busy(busy)
    );

    cmos_nvram_upload #(.INDEX(8'd4), .CMOS_AW(10), .RD_LAT(3)) u_dut3 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload3),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd3), .ioctl_addr(ioctl_addr3),
        .ioctl_din(ioctl_din3), .ioctl_wait(ioctl_wait3), .pause_req(pause_req3),
        .pause_ack(pause_ack3), .cmos_addr(cmos_addr3), .cmos_rd(cmos_rd3),
        .cmos_data(cmos_data3), .busy(busy3)
    );

    // CMOS models: data is only correct exactly RD_LAT cycles after the strobe,
    // the complement is presented at any other time.
    always @(posedge clk_sys) begin
        q1 <= cmos_rd ? mem[cmos_addr] : ~mem[cmos_addr];
        s0 <= cmos_rd3 ? mem[cmos_addr3] : ~mem[cmos_addr3];
        s1 <= s0;
        s2 <= s1;
        if (cmos_rd)  rd_pulses  <= rd_pulses + 1;
        if (cmos_rd3) rd_pulses3 <= rd_pulses3 + 1;
    end
    assign cmos_data  = q1;
    assign cmos_data3 = s2;

    function automatic logic [7:0] exp_byte(input int k);
        logic [10:0] n;
        n = 11'(2 * k);
        return {4'(n + 11'd1), 4'(n)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Walks edges 0..lat after the request edge; wait must hold until the last.
    task automatic wait_byte(input string tag, input int lat, input logic [7:0] exp, input int p0);
        for (int e = 0; e <= lat; e++) begin
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            if (e < lat) chk({tag, " wait_high"}, 32'(ioctl_wait), 32'd1);
        end
        chk({tag, " wait_low"}, 32'(ioctl_wait), 32'd0);
        chk({tag, " din"}, 32'(ioctl_din), 32'(exp));
        chk({tag, " cmos_rd_pulses"}, 32'(rd_pulses - p0), 32'd2);
    endtask

    task automatic read_byte(input string tag, input logic [24:0] a, input logic [7:0] exp);
        int p0;
        p0 = rd_pulses;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        wait_byte(tag, 5, exp, p0);
    endtask

    task automatic read_oor(input string tag, input logic [24:0] a);
        int p0;
        p0 = rd_pulses;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        tick();
        ioctl_rd = 1'b0;
        chk({tag, " din"}, 32'(ioctl_din), 32'hFF);
        chk({tag, " wait0"}, 32'(ioctl_wait), 32'd0);
        tick();
        chk({tag, " wait1"}, 32'(ioctl_wait), 32'd0);
        chk({tag, " cmos_rd_pulses"}, 32'(rd_pulses - p0), 32'd0);
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
        reset_n = 1'b0;
        ioctl_index = 16'd4;
        ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0; pause_ack = 1'b0;
        ioctl_upload3 = 1'b0; ioctl_rd3 = 1'b0; ioctl_addr3 = '0; pause_ack3 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst din", 32'(ioctl_din), 32'h00);
        chk("rst wait", 32'(ioctl_wait), 32'd0);
        chk("rst pause_req", 32'(pause_req), 32'd0);
        chk("rst cmos_addr", 32'(cmos_addr), 32'd0);
        chk("rst cmos_rd", 32'(cmos_rd), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick(); tick();

        // Wrong index: stays idle
        ioctl_index = 16'd0; ioctl_upload = 1'b1;
        tick(); tick(); tick(); tick();
        chk("wrongidx pause_req", 32'(pause_req), 32'd0);
        chk("wrongidx busy", 32'(busy), 32'd0);
        ioctl_upload = 1'b0; ioctl_index = 16'd4;
        tick();

        // Basic save, ack two cycles after pause_req
        ioctl_upload = 1'b1;
        tick();
        chk("open pause_req", 32'(pause_req), 32'd1);
        chk("open wait", 32'(ioctl_wait), 32'd1);
        chk("open busy", 32'(busy), 32'd1);
        tick();
        pause_ack = 1'b1;
        tick();
        chk("ready wait", 32'(ioctl_wait), 32'd0);
        for (int k = 0; k < 512; k++) begin
            read_byte($sformatf("save k=%0d", k), 25'(k), exp_byte(k));
            chk("save pause_req", 32'(pause_req), 32'd1);
            chk("save busy", 32'(busy), 32'd1);
        end

        // Out-of-range addresses
        read_oor("oor 512", 25'd512);
        read_oor("oor max", 25'h1FFFFFF);

        // Abort during WAIT_HI
        ioctl_rd = 1'b1; ioctl_addr = 25'd5;
        tick(); ioctl_rd = 1'b0;
        tick(); tick(); tick();
        ioctl_upload = 1'b0; pause_ack = 1'b0;
        tick();
        chk("abort pause_req", 32'(pause_req), 32'd0);
        chk("abort wait", 32'(ioctl_wait), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort cmos_rd", 32'(cmos_rd), 32'd0);
        chk("abort din_hold", 32'(ioctl_din), 32'hFF);
        tick(); tick();

        // New session, early request before ack
        ioctl_upload = 1'b1;
        tick();
        chk("restart pause_req", 32'(pause_req), 32'd1);
        chk("restart wait", 32'(ioctl_wait), 32'd1);
        p0 = rd_pulses;
        ioctl_rd = 1'b1; ioctl_addr = 25'd3;
        tick(); ioctl_rd = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("early wait", 32'(ioctl_wait), 32'd1);
            tick();
        end
        chk("early no_cmos_rd", 32'(rd_pulses - p0), 32'd0);
        pause_ack = 1'b1;
        wait_byte("early byte3", 5, 8'h76, p0);
        ioctl_upload = 1'b0; pause_ack = 1'b0;
        tick();
        chk("close busy", 32'(busy), 32'd0);

        // RD_LAT=3 instance: 9-edge latency
        ioctl_upload3 = 1'b1;
        tick(); pause_ack3 = 1'b1;
        tick(); tick();
        p0 = rd_pulses3;
        ioctl_rd3 = 1'b1; ioctl_addr3 = 25'd197;
        for (int e = 0; e <= 9; e++) begin
            tick();
            ioctl_rd3 = 1'b0;
            if (e < 9) chk("lat3 wait_high", 32'(ioctl_wait3), 32'd1);
        end
        chk("lat3 wait_low", 32'(ioctl_wait3), 32'd0);
        chk("lat3 din", 32'(ioctl_din3), 32'hBA);
        chk("lat3 cmos_rd_pulses", 32'(rd_pulses3 - p0), 32'd2);
        ioctl_upload3 = 1'b0; pause_ack3 = 1'b0;

        // Reset pulse in FETCH_LO
        ioctl_upload = 1'b1;
        tick(); tick(); pause_ack = 1'b1;
        tick();
        ioctl_rd = 1'b1; ioctl_addr = 25'd1;
        tick(); ioctl_rd = 1'b0;
        chk("fetchlo cmos_rd", 32'(cmos_rd), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst din", 32'(ioctl_din), 32'h00);
        chk("arst wait", 32'(ioctl_wait), 32'd0);
        chk("arst pause_req", 32'(pause_req), 32'd0);
        chk("arst cmos_addr", 32'(cmos_addr), 32'd0);
        chk("arst cmos_rd", 32'(cmos_rd), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst busy", 32'(busy), 32'd0);
        chk("post_rst pause_req", 32'(pause_req), 32'd0);
        chk("post_rst wait", 32'(ioctl_wait), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
